// File: rtl/csr_timer_pkg.sv
// Shared CSR definitions for the constant timer: addresses, TCFG field
// layout, write/read masks and the read-address decode helper.
package cpuDefine;

  localparam int TIMESIZE = 12;

  localparam logic [13:0] TCFG  = 14'h041;
  localparam logic [13:0] TVAL  = 14'h042;
  localparam logic [13:0] TICLR = 14'h044;

  localparam int TCFG_EN_BIT       = 0;
  localparam int TCFG_PERIODIC_BIT = 1;
  localparam int TCFG_INITVAL_LSB  = 2;

  function automatic logic [31:0] lo_mask(int w);
    if (w >= 32) return '1;
    return (32'h1 << w) - 32'h1;
  endfunction

  localparam logic [31:0] TCFG_WM  = lo_mask(TIMESIZE + 2);
  localparam logic [31:0] TCFG_RM  = TCFG_WM;
  localparam logic [31:0] TVAL_RM  = lo_mask(TIMESIZE);
  localparam logic [31:0] TICLR_RM = '0;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_TCFG,
    SEL_TVAL,
    SEL_TICLR
  } csr_sel_e;

  function automatic csr_sel_e csr_sel(logic [13:0] a);
    csr_sel_e s;
    s = SEL_NONE;
    if (a == TCFG) s = SEL_TCFG;
    else if (a == TVAL) s = SEL_TVAL;
    else if (a == TICLR) s = SEL_TICLR;
    return s;
  endfunction

endpackage

// File: rtl/csr_timer_if.sv
// CSR write/read port between the WB-stage CsrCtrl and the timer unit,
// plus the timer interrupt and stable-counter outputs.
interface csr_timer_if;
  logic        csr_wen;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_wmask;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_rhit;
  logic        timer_int;
  logic [63:0] stable_cnt;

  modport master (
    output csr_wen, csr_waddr, csr_wdata, csr_wmask, csr_raddr,
    input  csr_rdata, csr_rhit, timer_int, stable_cnt
  );

  modport slave (
    input  csr_wen, csr_waddr, csr_wdata, csr_wmask, csr_raddr,
    output csr_rdata, csr_rhit, timer_int, stable_cnt
  );
endinterface

// File: rtl/csr_timer_stable_counter.sv
// Free-running wrap-around counter behind rdcntvl.w / rdcntvh.w.
module stable_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= r_cnt + CNT_WIDTH'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/csr_timer.sv
// Constant timer (TCFG/TVAL/TICLR) with registered interrupt flag,
// and the stable counter instance.
module csr_timer #(
  parameter int TIMESIZE  = cpuDefine::TIMESIZE,
  parameter int CNT_WIDTH = 64
) (
  input  logic        aclk,
  input  logic        areset,
  csr_timer_if.slave  bus
);
  import cpuDefine::*;

  localparam int TW = TIMESIZE + 2;

  logic [TW-1:0]       r_tcfg;
  logic [TIMESIZE-1:0] r_tval;
  logic                r_ti;

  logic                 w_tcfg_wr;
  logic                 w_ticlr_wr;
  logic                 w_ti_clr;
  logic [TW-1:0]        w_wmask;
  logic [TW-1:0]        w_wdata;
  logic [TW-1:0]        w_tcfg_new;
  logic                 w_en;
  logic                 w_per;
  logic [TIMESIZE-1:0]  w_init;
  logic                 w_expire;
  csr_sel_e             w_rsel;
  logic [31:0]          w_rdata;
  logic [CNT_WIDTH-1:0] w_cnt;

  assign w_tcfg_wr  = bus.csr_wen && (bus.csr_waddr == TCFG);
  assign w_ticlr_wr = bus.csr_wen && (bus.csr_waddr == TICLR);
  assign w_ti_clr   = w_ticlr_wr && bus.csr_wdata[0] && bus.csr_wmask[0];

  // Bits above InitVal are not stored, so truncation is the write mask.
  assign w_wmask    = bus.csr_wmask[TW-1:0];
  assign w_wdata    = bus.csr_wdata[TW-1:0];
  assign w_tcfg_new = (r_tcfg & ~w_wmask) | (w_wdata & w_wmask);

  assign w_en   = r_tcfg[TCFG_EN_BIT];
  assign w_per  = r_tcfg[TCFG_PERIODIC_BIT];
  assign w_init = r_tcfg[TCFG_INITVAL_LSB +: TIMESIZE];

  // A TCFG write in the expiry cycle takes over TVAL and suppresses TI.
  assign w_expire = !w_tcfg_wr && w_en &&
                    (r_tval == TIMESIZE'(1));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_tcfg <= '0;
      r_tval <= '0;
      r_ti   <= 1'b0;
    end else begin
      if (w_tcfg_wr) begin
        r_tcfg <= w_tcfg_new;
        r_tval <= w_tcfg_new[TCFG_INITVAL_LSB +: TIMESIZE];
      end else if (w_en && (r_tval != '0)) begin
        if (w_expire) r_tval <= w_per ? w_init : '0;
        else          r_tval <= r_tval - TIMESIZE'(1);
      end
      if (w_expire)      r_ti <= 1'b1;
      else if (w_ti_clr) r_ti <= 1'b0;
    end
  end

  assign w_rsel = csr_sel(bus.csr_raddr);

  always_comb begin
    w_rdata = '0;
    unique case (w_rsel)
      SEL_TCFG: w_rdata = 32'(r_tcfg);
      SEL_TVAL: w_rdata = 32'(r_tval);
      default:  w_rdata = '0;
    endcase
  end

  stable_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_stable_counter (
    .i_clk (aclk),
    .i_rst (areset),
    .o_cnt (w_cnt)
  );

  assign bus.csr_rdata  = w_rdata;
  assign bus.csr_rhit   = (w_rsel != SEL_NONE);
  assign bus.timer_int  = r_ti;
  assign bus.stable_cnt = 64'(w_cnt);

endmodule

// File: tb/tb_csr_timer.sv
// Self-checking bench for csr_timer: directed timer scenarios plus a
// randomized run against a field-level reference model.
module tb_csr_timer;
  import cpuDefine::*;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  csr_timer_if bus();

  csr_timer #(
    .TIMESIZE  (12),
    .CNT_WIDTH (8)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int n_err = 0;
  int n_chk = 0;

  // Reference model: whole-register values and plain arithmetic.
  logic [31:0] m_tcfg = 0;
  logic [31:0] m_tval = 0;
  logic        m_ti   = 0;
  int          m_cnt  = 0;

  function automatic void m_reset();
    m_tcfg = 0; m_tval = 0; m_ti = 0; m_cnt = 0;
  endfunction

  function automatic void m_edge();
    bit wr, clr, fire;
    wr   = bus.csr_wen && bus.csr_waddr == TCFG;
    clr  = bus.csr_wen && bus.csr_waddr == TICLR &&
           bus.csr_wdata[0] && bus.csr_wmask[0];
    fire = 0;
    if (wr) begin
      m_tcfg = ((m_tcfg & ~bus.csr_wmask) |
                (bus.csr_wdata & bus.csr_wmask)) & 32'h3FFF;
      m_tval = m_tcfg / 4;
    end else if (m_tcfg % 2 == 1 && m_tval != 0) begin
      if (m_tval == 1) begin
        fire = 1;
        m_tval = ((m_tcfg / 2) % 2 == 1) ? m_tcfg / 4 : 0;
      end else begin
        m_tval = m_tval - 1;
      end
    end
    if (fire) m_ti = 1;
    else if (clr) m_ti = 0;
    m_cnt = (m_cnt + 1) % 256;
  endfunction

  task automatic cyc();
    @(posedge aclk);
    m_edge();
    @(negedge aclk);
    #1;
  endtask

  task automatic drive(input logic [13:0] a, input logic [31:0] d,
                       input logic [31:0] m);
    bus.csr_wen = 1'b1; bus.csr_waddr = a;
    bus.csr_wdata = d; bus.csr_wmask = m;
  endtask

  task automatic idle();
    bus.csr_wen = 1'b0; bus.csr_waddr = '0;
    bus.csr_wdata = '0; bus.csr_wmask = '0;
  endtask

  task automatic test_reset();
    idle();
    bus.csr_raddr = TCFG;
    #1;
    n_chk++;
    if (bus.timer_int !== 1'b0 || bus.stable_cnt !== 64'd0) begin
      n_err++;
      $display("FAIL reset_out ti=%0b cnt=%0d exp 0/0",
               bus.timer_int, bus.stable_cnt);
    end
    n_chk++;
    if (bus.csr_rdata !== 32'd0 || bus.csr_rhit !== 1'b1) begin
      n_err++;
      $display("FAIL reset_tcfg rdata=%h hit=%0b exp 0/1",
               bus.csr_rdata, bus.csr_rhit);
    end
    bus.csr_raddr = TVAL; #1;
    n_chk++;
    if (bus.csr_rdata !== 32'd0) begin
      n_err++;
      $display("FAIL reset_tval rdata=%h exp 0", bus.csr_rdata);
    end
    bus.csr_raddr = TICLR; #1;
    n_chk++;
    if (bus.csr_rdata !== 32'd0) begin
      n_err++;
      $display("FAIL reset_ticlr rdata=%h exp 0", bus.csr_rdata);
    end
    @(negedge aclk);
    areset = 1'b0;
    m_reset();
    #1;
  endtask

  task automatic test_oneshot();
    logic [31:0] exp_v [8] = '{5, 4, 3, 2, 1, 0, 0, 0};
    logic        exp_i [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    bus.csr_raddr = TVAL;
    drive(TCFG, 32'h15, 32'hFFFF_FFFF);
    cyc();
    idle();
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (bus.csr_rdata !== exp_v[i] || bus.timer_int !== exp_i[i]) begin
        n_err++;
        $display("FAIL oneshot i=%0d tval=%0d ti=%0b exp %0d/%0b",
                 i, bus.csr_rdata, bus.timer_int, exp_v[i], exp_i[i]);
      end
      cyc();
    end
  endtask

  task automatic test_periodic();
    logic [31:0] exp_v [10] = '{3, 2, 1, 3, 2, 1, 3, 2, 1, 3};
    logic        exp_i [10] = '{0, 0, 0, 1, 1, 0, 1, 1, 1, 1};
    bus.csr_raddr = TVAL;
    drive(TICLR, 32'h1, 32'hFFFF_FFFF);
    cyc();
    drive(TCFG, 32'h0F, 32'hFFFF_FFFF);
    cyc();
    idle();
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (bus.csr_rdata !== exp_v[i] || bus.timer_int !== exp_i[i]) begin
        n_err++;
        $display("FAIL periodic i=%0d tval=%0d ti=%0b exp %0d/%0b",
                 i, bus.csr_rdata, bus.timer_int, exp_v[i], exp_i[i]);
      end
      if (i == 4) drive(TICLR, 32'h1, 32'h1);
      else idle();
      cyc();
    end
    idle();
  endtask

  task automatic test_collision();
    bus.csr_raddr = TVAL;
    for (int g = 0; g < 8 && m_tval != 2; g++) cyc();
    n_chk++;
    if (m_tval != 2) begin
      n_err++;
      $display("FAIL coll_wait tval=%0d exp 2", m_tval);
    end
    drive(TICLR, 32'h1, 32'h1);
    cyc();
    drive(TICLR, 32'h1, 32'h1);
    cyc();
    idle();
    n_chk++;
    if (bus.timer_int !== 1'b1 || bus.csr_rdata !== 32'd3) begin
      n_err++;
      $display("FAIL coll_ticlr ti=%0b tval=%0d exp 1/3",
               bus.timer_int, bus.csr_rdata);
    end
    drive(TICLR, 32'h1, 32'h1);
    cyc();
    idle();
    cyc();
    n_chk++;
    if (bus.timer_int !== 1'b0 || bus.csr_rdata !== 32'd1) begin
      n_err++;
      $display("FAIL coll_setup ti=%0b tval=%0d exp 0/1",
               bus.timer_int, bus.csr_rdata);
    end
    drive(TCFG, 32'h1D, 32'hFFFF_FFFF);
    cyc();
    idle();
    n_chk++;
    if (bus.timer_int !== 1'b0 || bus.csr_rdata !== 32'd7) begin
      n_err++;
      $display("FAIL coll_tcfg ti=%0b tval=%0d exp 0/7",
               bus.timer_int, bus.csr_rdata);
    end
    cyc();
    n_chk++;
    if (bus.csr_rdata !== 32'd6) begin
      n_err++;
      $display("FAIL coll_after tval=%0d exp 6", bus.csr_rdata);
    end
  endtask

  task automatic test_xchg();
    drive(TICLR, 32'h1, 32'h1);
    cyc();
    drive(TCFG, 32'h15, 32'hFFFF_FFFF);
    cyc();
    drive(TCFG, 32'h0, 32'h1);
    bus.csr_raddr = TCFG;
    cyc();
    idle();
    n_chk++;
    if (bus.csr_rdata !== 32'h14) begin
      n_err++;
      $display("FAIL xchg_tcfg rdata=%h exp 14", bus.csr_rdata);
    end
    bus.csr_raddr = TVAL;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_chk++;
      if (bus.csr_rdata !== 32'd5 || bus.timer_int !== 1'b0) begin
        n_err++;
        $display("FAIL xchg_freeze i=%0d tval=%0d ti=%0b exp 5/0",
                 i, bus.csr_rdata, bus.timer_int);
      end
      cyc();
    end
  endtask

  task automatic test_random();
    logic [13:0] addrs [4] = '{TCFG, TVAL, TICLR, 14'h043};
    logic [31:0] d, m, exp_r;
    logic [13:0] ra;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 4) begin
        d = ($urandom & 32'hFFFF_C000) |
            ($urandom_range(0, 6) << 2) | $urandom_range(0, 3);
        m = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
        drive(addrs[$urandom_range(0, 3)], d, m);
      end else begin
        idle();
      end
      ra = addrs[$urandom_range(0, 3)];
      bus.csr_raddr = ra;
      cyc();
      exp_r = (ra == TCFG) ? m_tcfg : (ra == TVAL) ? m_tval : 32'd0;
      n_chk++;
      if (bus.csr_rdata !== exp_r || bus.timer_int !== m_ti ||
          bus.csr_rhit !== (ra != 14'h043) ||
          bus.stable_cnt !== 64'(m_cnt)) begin
        n_err++;
        $display("FAIL rand i=%0d ra=%h rd=%h/%h ti=%0b/%0b cnt=%0d/%0d",
                 i, ra, bus.csr_rdata, exp_r, bus.timer_int, m_ti,
                 bus.stable_cnt, m_cnt);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    bus.csr_raddr = TVAL;
    drive(TCFG, 32'h21, 32'hFFFF_FFFF);
    cyc();
    idle();
    cyc(); cyc(); cyc();
    @(posedge aclk);
    #2 areset = 1'b1;
    #1;
    n_chk++;
    if (bus.csr_rdata !== 32'd0 || bus.timer_int !== 1'b0 ||
        bus.stable_cnt !== 64'd0) begin
      n_err++;
      $display("FAIL mid_reset tval=%0d ti=%0b cnt=%0d exp 0/0/0",
               bus.csr_rdata, bus.timer_int, bus.stable_cnt);
    end
    bus.csr_raddr = TCFG; #1;
    n_chk++;
    if (bus.csr_rdata !== 32'd0) begin
      n_err++;
      $display("FAIL mid_reset_tcfg rdata=%h exp 0", bus.csr_rdata);
    end
    @(negedge aclk);
    areset = 1'b0;
    m_reset();
    #1;
    bus.csr_raddr = TVAL;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_chk++;
      if (bus.csr_rdata !== 32'd0 || bus.timer_int !== 1'b0) begin
        n_err++;
        $display("FAIL mid_resume i=%0d tval=%0d ti=%0b exp 0/0",
                 i, bus.csr_rdata, bus.timer_int);
      end
    end
  endtask

  task automatic test_stable();
    bit hi_bad = 0;
    @(posedge aclk);
    #2 areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    m_reset();
    #1;
    for (int i = 1; i <= 256; i++) begin
      cyc();
      if (bus.stable_cnt[63:8] != 0) hi_bad = 1;
      if (i == 255) begin
        n_chk++;
        if (bus.stable_cnt !== 64'd255) begin
          n_err++;
          $display("FAIL stable_255 cnt=%0d exp 255", bus.stable_cnt);
        end
      end
      if (i == 256) begin
        n_chk++;
        if (bus.stable_cnt !== 64'd0) begin
          n_err++;
          $display("FAIL stable_wrap cnt=%0d exp 0", bus.stable_cnt);
        end
      end
    end
    n_chk++;
    if (hi_bad) begin
      n_err++;
      $display("FAIL stable_upper nonzero=1 exp 0");
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_collision();
    test_xchg();
    test_random();
    test_reset_mid();
    test_stable();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
